// File: rtl/mul_pkg.sv
// mul_pkg: shared types and opcode decode helpers for the iterative multiplier.
//   mul_op_e    : RV M-extension multiply flavour (MUL / MULH / MULHSU / MULHU)
//   mul_state_e : sequencer state, also exported on the debug port of mul_iter_unit
//   op_rs1_signed / op_rs2_signed : operand signedness for a given opcode
//   op_high     : 1 when the upper half of the double-width product is returned
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  function automatic logic op_rs1_signed(input mul_op_e op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_rs2_signed(input mul_op_e op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

  function automatic logic op_high(input mul_op_e op);
    return op != MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/mul_chunk.sv
// mul_chunk: combinational product of an XLEN-bit multiplicand and a CHUNK-bit
// multiplier slice. One shifted partial product per slice bit, summed in a
// balanced binary adder tree.
// Ports:
//   mcand  in   XLEN         unsigned multiplicand
//   slice  in   CHUNK        unsigned multiplier slice
//   prod   out  XLEN+CHUNK   mcand * slice (exact, never overflows)
module mul_chunk #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 11
) (
  input  logic [XLEN-1:0]       mcand,
  input  logic [CHUNK-1:0]      slice,
  output logic [XLEN+CHUNK-1:0] prod
);

  localparam int PROD_W = XLEN + CHUNK;
  localparam int LVL    = (CHUNK > 1) ? $clog2(CHUNK) : 0;
  localparam int NP     = 1 << LVL;

  // Heap-ordered tree: leaves live at NP..2*NP-1, node j sums children 2j and
  // 2j+1, root at index 1. Leaves past CHUNK stay zero. Index 0 is unused.
  logic [PROD_W-1:0] node [2*NP];

  always_comb begin
    for (int i = 0; i < 2*NP; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < CHUNK; i++) begin
      node[NP+i] = slice[i] ? (PROD_W'(mcand) << i) : '0;
    end
    for (int j = NP-1; j >= 1; j--) begin
      node[j] = node[2*j] + node[2*j+1];
    end
  end

  assign prod = node[1];

endmodule

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: multi-cycle RV32/RV64 M-extension multiplier.
// Sign-magnitude datapath: operands are converted to magnitudes at accept, the
// magnitude product is accumulated CHUNK multiplier bits per cycle, and the sign
// is applied once at the end. The operand with fewer significant bits is used
// as multiplier so short operands finish early.
// Ports:
//   CLK        in   1     clock, rising edge
//   RST        in   1     synchronous active-high reset
//   START      in   1     request valid
//   READY      out  1     idle, request accepted when START && READY && !FLUSH
//   FLUSH      in   1     abandon the in-flight operation
//   RS1, RS2   in   XLEN  operands, sampled only at accept
//   MUL_OP     in   2     mul_op_e encoding
//   DONE       out  1     one-cycle pulse, RESULT valid in the same cycle
//   RESULT     out  XLEN  selected product half, held until the next DONE
//   DBG_STATE  out  2     sequencer state for observation
//
// Handshake: a request transfers on a rising edge where START && READY are both
// high and FLUSH is low. The requester must hold RS1/RS2/MUL_OP stable while
// START is high and READY is low; START is ignored outside IDLE.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             READY,
  input  logic             FLUSH,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  RS2,
  input  logic [1:0]       MUL_OP,
  output logic             DONE,
  output logic [XLEN-1:0]  RESULT,
  output mul_state_e       DBG_STATE
);

  localparam int ACC_W  = 2 * XLEN;
  localparam int PROD_W = XLEN + CHUNK;
  localparam int STEPS  = (XLEN + CHUNK - 1) / CHUNK;
  localparam int K_W    = $clog2(STEPS + 1);

  // Number of significant bits (index of the top set bit plus one, 0 for 0).
  function automatic int sig_bits(input logic [XLEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  mul_state_e        state_q, state_d;
  logic [XLEN-1:0]   mcand_q, mplier_q;
  logic [ACC_W-1:0]  acc_q;
  logic [K_W-1:0]    k_q;
  logic              neg_q;
  mul_op_e           op_q;
  logic [XLEN-1:0]   result_q;

  // Accept-side operand conditioning.
  mul_op_e           op_in;
  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              rs1_is_mplier;
  logic              accept;

  assign op_in  = mul_op_e'(MUL_OP);
  assign sign1  = op_rs1_signed(op_in) && RS1[XLEN-1];
  assign sign2  = op_rs2_signed(op_in) && RS2[XLEN-1];
  // The most-negative value maps onto itself, which read unsigned is the
  // correct magnitude.
  assign mag1   = sign1 ? (~RS1 + XLEN'(1)) : RS1;
  assign mag2   = sign2 ? (~RS2 + XLEN'(1)) : RS2;
  // Ties keep RS2 as multiplier.
  assign rs1_is_mplier = sig_bits(mag1) < sig_bits(mag2);
  assign accept = (state_q == ST_IDLE) && START && !FLUSH;

  // Iteration datapath.
  logic [PROD_W-1:0] chunk_prod;
  logic [ACC_W-1:0]  acc_next;
  logic [XLEN-1:0]   mplier_next;

  mul_chunk #(
    .XLEN  (XLEN),
    .CHUNK (CHUNK)
  ) u_chunk (
    .mcand (mcand_q),
    .slice (mplier_q[CHUNK-1:0]),
    .prod  (chunk_prod)
  );

  // Carries past 2*XLEN are discarded by the accumulator width.
  assign acc_next    = acc_q + (ACC_W'(chunk_prod) << (int'(k_q) * CHUNK));
  assign mplier_next = mplier_q >> CHUNK;

  // Sign application and half select.
  logic [ACC_W-1:0]  acc_signed;
  logic [XLEN-1:0]   final_res;

  assign acc_signed = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
  assign final_res  = op_high(op_q) ? acc_signed[ACC_W-1:XLEN]
                                    : acc_signed[XLEN-1:0];

  // Sequencer.
  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    DONE    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        READY = 1'b1;
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Exit is judged on the multiplier after this cycle's shift, so a zero
        // multiplier still spends exactly one cycle here.
        if (FLUSH)                  state_d = ST_IDLE;
        else if (mplier_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A flush arriving in this cycle suppresses the completion entirely.
        DONE    = !FLUSH;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign RESULT    = DONE ? final_res : result_q;
  assign DBG_STATE = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      neg_q    <= 1'b0;
      op_q     <= MUL_OP_MUL;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q  <= rs1_is_mplier ? mag2 : mag1;
        mplier_q <= rs1_is_mplier ? mag1 : mag2;
        acc_q    <= '0;
        k_q      <= '0;
        // A zero operand forces a positive result.
        neg_q    <= (sign1 ^ sign2) && (mag1 != '0) && (mag2 != '0);
        op_q     <= op_in;
      end else if ((state_q == ST_RUN) && !FLUSH) begin
        acc_q    <= acc_next;
        mplier_q <= mplier_next;
        k_q      <= k_q + K_W'(1);
      end
      if (DONE) result_q <= final_res;
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit (XLEN=32, CHUNK=11): directed corner operations,
// flush/reset scenarios and a back-to-back random stream, all checked against
// a 64-bit arithmetic reference model.
module tb_mul_iter_unit;
  import mul_pkg::*;

  localparam int XLEN   = 32;
  localparam int CHUNK  = 11;
  localparam int N_OPS  = 10000;

  logic             clk = 1'b0;
  logic             rst, start, flush;
  logic             ready, done;
  logic [XLEN-1:0]  rs1, rs2, result;
  logic [1:0]       mul_op;
  mul_state_e       dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];

  mul_iter_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .READY     (ready),
    .FLUSH     (flush),
    .RS1       (rs1),
    .RS2       (rs2),
    .MUL_OP    (mul_op),
    .DONE      (done),
    .RESULT    (result),
    .DBG_STATE (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    rs1 = '0; rs2 = '0; mul_op = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    longint    sa, sb;
    logic [63:0] p;
    sa = (op != 2'b11) ? longint'(signed'(a)) : longint'(a);
    sb = (op <= 2'b01) ? longint'(signed'(b)) : longint'(b);
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int nbits(input logic [XLEN-1:0] v);
    int n;
    n = 0;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  // Cycles from accept edge to the DONE cycle: one per CHUNK bits of the
  // shorter magnitude (at least one), plus one for the completion cycle.
  function automatic int ref_latency(input logic [1:0] op,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic [XLEN-1:0] ma, mb;
    int m, runs;
    ma = ((op != 2'b11) && a[XLEN-1]) ? -a : a;
    mb = ((op <= 2'b01) && b[XLEN-1]) ? -b : b;
    m  = (nbits(ma) < nbits(mb)) ? nbits(ma) : nbits(mb);
    runs = (m == 0) ? 1 : (m + CHUNK - 1) / CHUNK;
    return 1 + runs;
  endfunction

  // ---------------- driver ----------------
  // Entered and left in IDLE, sampled #1 after a rising edge.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int   lat;
    logic rdy_low;
    logic [XLEN-1:0] exp_r;
    exp_r  = ref_result(op, a, b);
    mul_op = op; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    start   = 1'b0;
    lat     = 1;
    rdy_low = 1'b1;
    while (!done && lat < 20) begin
      if (ready) rdy_low = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_done"},    64'(done),    64'd1);
    check({tag, "_result"},  64'(result),  64'(exp_r));
    check({tag, "_latency"}, 64'(lat),     64'(ref_latency(op, a, b)));
    check({tag, "_busy"},    64'(rdy_low), 64'd1);
    tick();
    check({tag, "_pulse"},   64'(done),    64'd0);
    check({tag, "_idle"},    64'(ready),   64'd1);
    check({tag, "_held"},    64'(result),  64'(exp_r));
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom >> $urandom_range(0, 31);
      2: case ($urandom_range(0, 4))
           0: v = 32'h0;
           1: v = 32'h1;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      default: v = -($urandom >> $urandom_range(8, 31));
    endcase
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    int   cyc, accepts, dones;
    logic [1:0] op;

    reset_dut();
    check("reset_ready",  64'(ready),     64'd1);
    check("reset_done",   64'(done),      64'd0);
    check("reset_result", 64'(result),    64'd0);
    check("reset_state",  64'(dbg_state), 64'(ST_IDLE));

    // Directed operations.
    run_op("mul_7_m3",      2'b00, 32'd7,        32'hFFFF_FFFD);
    run_op("mulh_min_min",  2'b01, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu_max_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_m1_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_early_800", 2'b00, 32'h1234_5678, 32'h0000_0800);
    run_op("mul_early_4e5", 2'b00, 32'h1234_5678, 32'h0040_0000);
    run_op("mul_zero",      2'b00, 32'h0,         32'h8000_0000);
    run_op("mulh_neg_zero", 2'b01, 32'hFFFF_FFF0, 32'h0);
    run_op("mul_m5_7",      2'b00, 32'hFFFF_FFFB, 32'd7);

    // FLUSH one cycle into a long MULHU: no completion, back to IDLE, RESULT held.
    run_op("pre_flush", 2'b00, 32'd7, 32'hFFFF_FFFD);
    mul_op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b1;
    check("flush_run_state", 64'(dbg_state), 64'(ST_RUN));
    tick();
    flush = 1'b0;
    check("flush_run_ready", 64'(ready),  64'd1);
    check("flush_run_held",  64'(result), 64'hFFFF_FFEB);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("flush_run_nodone", 64'(seen), 64'd0);
    run_op("after_flush", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // FLUSH landing in the completion cycle.
    mul_op = 2'b00; rs1 = 32'd5; rs2 = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_done_state", 64'(dbg_state), 64'(ST_DONE));
    check("flush_done_pulse", 64'(done),      64'd0);
    check("flush_done_res",   64'(result),    64'hFFFF_FFFE);
    tick();
    flush = 1'b0;
    check("flush_done_ready", 64'(ready),  64'd1);
    check("flush_done_held",  64'(result), 64'hFFFF_FFFE);

    // FLUSH and START together in IDLE: nothing accepted.
    mul_op = 2'b00; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", 64'(ready),     64'd1);
    check("flush_start_state", 64'(dbg_state), 64'(ST_IDLE));

    // Reset in the middle of RUN, with START still asserted.
    mul_op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    check("rst_mid_state_run", 64'(dbg_state), 64'(ST_RUN));
    rst = 1'b1;
    tick();
    check("rst_mid_ready",  64'(ready),     64'd1);
    check("rst_mid_done",   64'(done),      64'd0);
    check("rst_mid_result", 64'(result),    64'd0);
    check("rst_mid_state",  64'(dbg_state), 64'(ST_IDLE));
    start = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_hold_state", 64'(dbg_state), 64'(ST_IDLE));
    run_op("after_rst", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000);

    // Back-to-back random stream with START held high.
    cyc = 0; accepts = 0; dones = 0;
    start = 1'b1;
    while ((accepts < N_OPS || exp_q.size() != 0) && cyc < 8 * N_OPS) begin
      if (done) begin
        dones++;
        if (exp_q.size() == 0) begin
          check("rnd_spurious_done", 64'd1, 64'd0);
        end else begin
          check("rnd_result",  64'(result), 64'(exp_q.pop_front()));
          check("rnd_latency", 64'(cyc),    64'(lat_q.pop_front()));
        end
      end
      if (ready) begin
        if (accepts < N_OPS) begin
          op     = 2'($urandom_range(0, 3));
          mul_op = op;
          rs1    = rand_operand();
          rs2    = rand_operand();
          start  = 1'b1;
          exp_q.push_back(ref_result(op, rs1, rs2));
          lat_q.push_back(cyc + ref_latency(op, rs1, rs2));
          accepts++;
        end else begin
          start = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("rnd_finished", 64'(exp_q.size()), 64'd0);
    check("rnd_done_count", 64'(dones), 64'(accepts));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
